// File: rtl/incr_share_ctrl_if.sv
// Requester-side and incrementer-side bus of the shared incrementer controller.
// The controller connects through the slave modport; the requester FSMs and the
// shared incrementer instance (or a bench) use the master modport.
interface incr_share_ctrl_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N_REQ = 4
);
    // Requester side
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] opnd;
    logic [N_REQ-1:0]       gnt;
    logic [N_REQ-1:0]       done;
    logic [WIDTH-1:0]       result;
    logic                   co;
    logic                   busy;

    // Shared ripple incrementer side
    logic [WIDTH-1:0]       inc_a;
    logic                   inc_cin;
    logic [WIDTH-1:0]       inc_sum;
    logic                   inc_co;

    modport master (
        output req, opnd, inc_sum, inc_co,
        input  gnt, done, result, co, busy, inc_a, inc_cin
    );

    modport slave (
        input  req, opnd, inc_sum, inc_co,
        output gnt, done, result, co, busy, inc_a, inc_cin
    );
endinterface

// File: rtl/incr_share_ctrl.sv
// Time-shares one multi-cycle ripple incrementer among N_REQ requesters.
// Round-robin grant, operand held for SETTLE_CYCLES, then sum/carry captured
// and a one-cycle done pulse returned to the owner.
module incr_share_ctrl #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned N_REQ         = 4,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    incr_share_ctrl_if.slave  bus
);

    localparam int unsigned PTR_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [3:0]  CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               co_q, co_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [3:0]         cnt_q, cnt_d;

    logic               win_found;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W-1:0]   cand;

    // Round-robin search: first asserted req starting at rr_ptr, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = PTR_W'((32'(rr_ptr_q) + i) % N_REQ);
            if (!win_found && bus.req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Next-state and capture logic; req is only looked at in IDLE.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        done_d   = '0;
        result_d = result_q;
        co_d     = co_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    gnt_d          = '0;
                    gnt_d[win_idx] = 1'b1;
                    rr_ptr_d       = PTR_W'((32'(win_idx) + 32'd1) % N_REQ);
                    cnt_d          = CNT_LOAD;
                    state_d        = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    result_d = bus.inc_sum;
                    co_d     = bus.inc_co;
                    done_d   = gnt_q;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously (aborts in-flight op).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            done_q   <= '0;
            result_q <= '0;
            co_q     <= 1'b0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            result_q <= result_d;
            co_q     <= co_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Operand mux from the registered grant; driven through WAIT and DONE only.
    always_comb begin
        bus.inc_a   = '0;
        bus.inc_cin = 1'b0;
        if (state_q != IDLE) begin
            bus.inc_cin = 1'b1;
            for (int unsigned k = 0; k < N_REQ; k++) begin
                if (gnt_q[k]) begin
                    bus.inc_a = bus.opnd[k*WIDTH +: WIDTH];
                end
            end
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.co     = co_q;
    assign bus.busy   = (state_q != IDLE);

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst)
        $onehot0(gnt_q));
    a_done_onehot0: assert property (@(posedge clk) disable iff (rst)
        $onehot0(done_q));
    a_done_has_gnt: assert property (@(posedge clk) disable iff (rst)
        ((done_q & gnt_q) == done_q));
    a_cnt_range: assert property (@(posedge clk) disable iff (rst)
        (cnt_q <= CNT_LOAD));

endmodule

// File: tb/tb_incr_share_ctrl.sv
// Directed bench for incr_share_ctrl with a 3-cycle-delay behavioural ripple incrementer.
module tb_incr_share_ctrl;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned N_REQ  = 4;
    localparam int unsigned SETTLE = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;

    incr_share_ctrl_if #(.WIDTH(WIDTH), .N_REQ(N_REQ)) bus ();

    incr_share_ctrl #(
        .WIDTH(WIDTH),
        .N_REQ(N_REQ),
        .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Incrementer whose output reflects the operand only 3 edges later.
    logic [WIDTH-1:0] a1 = '0, a2 = '0, a3 = '0;
    logic             c1 = 1'b0, c2 = 1'b0, c3 = 1'b0;
    logic [WIDTH:0]   rip;
    always @(posedge clk) begin
        a1 <= bus.inc_a;   c1 <= bus.inc_cin;
        a2 <= a1;          c2 <= c1;
        a3 <= a2;          c3 <= c2;
    end
    assign rip         = {1'b0, a3} + {{WIDTH{1'b0}}, c3};
    assign bus.inc_sum = rip[WIDTH-1:0];
    assign bus.inc_co  = rip[WIDTH];

    typedef struct {
        logic [3:0]  req;
        logic [31:0] opnd;
        logic [3:0]  gnt;
        logic [7:0]  a;
        logic [7:0]  res;
        logic        co;
        string       name;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_idle_outputs(input string nm);
        chk({nm, "_gnt"},    32'(bus.gnt),     32'h0);
        chk({nm, "_done"},   32'(bus.done),    32'h0);
        chk({nm, "_busy"},   32'(bus.busy),    32'h0);
        chk({nm, "_inc_a"},  32'(bus.inc_a),   32'h0);
        chk({nm, "_cin"},    32'(bus.inc_cin), 32'h0);
    endtask

    // One full operation: grant after E0, done in the cycle after E(SETTLE), back to IDLE.
    task automatic do_op(input vec_t v, input bit drop_early);
        bus.req  = v.req;
        bus.opnd = v.opnd;
        @(negedge clk);
        chk({v.name, "_gnt"},   32'(bus.gnt),     32'(v.gnt));
        chk({v.name, "_busy"},  32'(bus.busy),    32'h1);
        chk({v.name, "_inc_a"}, 32'(bus.inc_a),   32'(v.a));
        chk({v.name, "_cin"},   32'(bus.inc_cin), 32'h1);
        if (drop_early) bus.req = '0;
        chk({v.name, "_early_done"}, 32'(bus.done), 32'h0);
        for (int i = 1; i < int'(SETTLE); i++) begin
            @(negedge clk);
            chk({v.name, "_wait_done"}, 32'(bus.done), 32'h0);
            chk({v.name, "_wait_gnt"},  32'(bus.gnt),  32'(v.gnt));
        end
        @(negedge clk);
        chk({v.name, "_done"},   32'(bus.done),   32'(v.gnt));
        chk({v.name, "_dgnt"},   32'(bus.gnt),    32'(v.gnt));
        chk({v.name, "_result"}, 32'(bus.result), 32'(v.res));
        chk({v.name, "_co"},     32'(bus.co),     32'(v.co));
        chk({v.name, "_dcin"},   32'(bus.inc_cin), 32'h1);
        bus.req = bus.req & ~v.gnt;
        @(negedge clk);
        chk_idle_outputs({v.name, "_after"});
        chk({v.name, "_hold_res"}, 32'(bus.result), 32'(v.res));
        chk({v.name, "_hold_co"},  32'(bus.co),     32'(v.co));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: time %0t exceeded limit 400000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        bit   found;
        int   waited;
        int   last_done;
        logic [8:0] exp9;

        // Fairness from reset (rows 0-4), then pointer behaviour and arithmetic edges.
        tbl[0] = '{4'b1111, 32'h4030FF3C, 4'b0001, 8'h3C, 8'h3D, 1'b0, "fair0"};
        tbl[1] = '{4'b1111, 32'h4030FF3C, 4'b0010, 8'hFF, 8'h00, 1'b1, "fair1_wrap"};
        tbl[2] = '{4'b1111, 32'h4030FF3C, 4'b0100, 8'h30, 8'h31, 1'b0, "fair2"};
        tbl[3] = '{4'b1111, 32'h4030FF3C, 4'b1000, 8'h40, 8'h41, 1'b0, "fair3"};
        tbl[4] = '{4'b1111, 32'h4030FF3C, 4'b0001, 8'h3C, 8'h3D, 1'b0, "fair4"};
        tbl[5] = '{4'b0100, 32'h007F0000, 4'b0100, 8'h7F, 8'h80, 1'b0, "single2"};
        tbl[6] = '{4'b1001, 32'h100000A5, 4'b1000, 8'h10, 8'h11, 1'b0, "ptrwrap3"};
        tbl[7] = '{4'b1001, 32'h100000A5, 4'b0001, 8'hA5, 8'hA6, 1'b0, "ptrwrap0"};
        tbl[8] = '{4'b0001, 32'h000000FE, 4'b0001, 8'hFE, 8'hFF, 1'b0, "single0_fe"};
        tbl[9] = '{4'b0011, 32'h000000FE, 4'b0010, 8'h00, 8'h01, 1'b0, "rr_from1"};

        bus.req  = '0;
        bus.opnd = '0;
        rst      = 1'b1;
        repeat (2) @(negedge clk);
        chk_idle_outputs("reset");
        chk("reset_result", 32'(bus.result), 32'h0);
        chk("reset_co",     32'(bus.co),     32'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int r = 0; r < 10; r++) do_op(tbl[r], 1'b0);

        // req dropped right after grant: operation still completes.
        v = '{4'b0010, 32'h00005500, 4'b0010, 8'h55, 8'h56, 1'b0, "drop_wait"};
        do_op(v, 1'b1);

        // Reset in the middle of WAIT: everything clears and no done follows.
        bus.req  = 4'b0001;
        bus.opnd = 32'h00000011;
        @(negedge clk);
        chk("abort_gnt", 32'(bus.gnt), 32'h1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk_idle_outputs("abort_rst");
        chk("abort_result", 32'(bus.result), 32'h0);
        chk("abort_co",     32'(bus.co),     32'h0);
        bus.req = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < int'(SETTLE) + 2; i++) begin
            @(negedge clk);
            chk("abort_nodone", 32'(bus.done), 32'h0);
            chk("abort_nobusy", 32'(bus.busy), 32'h0);
        end
        v = '{4'b0100, 32'h009A0000, 4'b0100, 8'h9A, 8'h9B, 1'b0, "post_rst2"};
        do_op(v, 1'b0);
        v = '{4'b0011, 32'h00000180, 4'b0001, 8'h80, 8'h81, 1'b0, "post_rst_rr"};
        do_op(v, 1'b0);

        // Back-to-back sweep of all operands on requester 0.
        last_done = 0;
        for (int val = 0; val < 256; val++) begin
            bus.opnd = {24'h0, 8'(val)};
            bus.req  = 4'b0001;
            found    = 1'b0;
            waited   = 0;
            while (!found && waited < 20) begin
                @(negedge clk);
                waited++;
                if (bus.done != '0) found = 1'b1;
            end
            exp9 = 9'(val) + 9'd1;
            chk("sweep_done",   32'(bus.done),   32'h1);
            chk("sweep_result", 32'(bus.result), 32'(exp9[7:0]));
            chk("sweep_co",     32'(bus.co),     32'(exp9[8]));
            if (val > 0) chk("sweep_spacing", 32'(cyc - last_done), 32'd6);
            last_done = cyc;
            @(negedge clk);
        end
        bus.req = '0;
        repeat (3) @(negedge clk);
        chk("final_idle", 32'(bus.busy), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
